// File: rtl/scan_colunas_pkg.sv
// Shared definitions for the column-scan display driver: FSM encoding,
// row width and the default matrix geometry.
package scan_colunas_pkg;
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} estado_t;

    localparam int LARG_LINHA   = 7;
    localparam int N_COL_PADRAO = 5;
    localparam int DIV_PADRAO   = 4;
endpackage

// File: rtl/scan_colunas_if.sv
// Frame load / column drive bus between the frame source (master) and
// the scanner (slave).
interface scan_colunas_if
    import scan_colunas_pkg::*;
#(
    parameter int N_COL = N_COL_PADRAO
);
    logic                        en;
    logic [LARG_LINHA*N_COL-1:0] dados_in;
    logic                        carregar;
    logic [N_COL-1:0]            colunas;
    logic [LARG_LINHA-1:0]       linhas;
    logic                        sinal;
    logic                        fim_quadro;

    modport master (output en, dados_in, carregar,
                    input  colunas, linhas, sinal, fim_quadro);
    modport slave  (input  en, dados_in, carregar,
                    output colunas, linhas, sinal, fim_quadro);
endinterface

// File: rtl/scan_colunas_contador.sv
// Prescaler plus column index; both sit at zero whenever en is low so a
// restarted scan always begins at column 0, prescaler 0.
module contador_varredura
    import scan_colunas_pkg::*;
#(
    parameter int N_COL = N_COL_PADRAO,
    parameter int DIV   = DIV_PADRAO,
    localparam int CW   = (N_COL > 1) ? $clog2(N_COL) : 1,
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] coluna,
    output logic          passo,
    output logic          ultimo
);
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] coluna_q, coluna_d;

    // passo marks the last prescaler count of a column; ultimo the last column
    assign passo  = (presc_q == PW'(DIV - 1));
    assign ultimo = (coluna_q == CW'(N_COL - 1));
    assign coluna = coluna_q;

    always_comb begin
        presc_d  = presc_q;
        coluna_d = coluna_q;
        if (!en) begin
            presc_d  = '0;
            coluna_d = '0;
        end else if (passo) begin
            presc_d  = '0;
            coluna_d = ultimo ? '0 : coluna_q + 1'b1;
        end else begin
            presc_d  = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            coluna_q <= '0;
        end else begin
            presc_q  <= presc_d;
            coluna_q <= coluna_d;
        end
    end
endmodule

// File: rtl/scan_colunas.sv
// Multiplexed LED-matrix column scanner with double-buffered frame so a new
// frame is only shown from column 0 of a fresh scan.
module scan_colunas
    import scan_colunas_pkg::*;
#(
    parameter int N_COL = N_COL_PADRAO,
    parameter int DIV   = DIV_PADRAO,
    localparam int CW   = (N_COL > 1) ? $clog2(N_COL) : 1
) (
    input logic           clk,
    input logic           rst,
    scan_colunas_if.slave bus
);
    typedef logic [N_COL-1:0][LARG_LINHA-1:0] quadro_t;

    estado_t       estado_q;
    logic [CW-1:0] coluna;
    logic          passo, ultimo, varrendo, fim;
    quadro_t       sombra_q, sombra_d, quadro_q, quadro_d;
    logic          pendente_q, pendente_d;

    always_ff @(posedge clk) begin
        if (rst) estado_q <= IDLE;
        else     estado_q <= bus.en ? SCAN : IDLE;
    end

    assign varrendo = (estado_q == SCAN);
    assign fim      = varrendo && passo && ultimo;

    contador_varredura #(.N_COL(N_COL), .DIV(DIV)) u_cont (
        .clk    (clk),
        .rst    (rst),
        .en     (varrendo && bus.en),
        .coluna (coluna),
        .passo  (passo),
        .ultimo (ultimo)
    );

    // Shadow swaps in at frame end or while idle; a load landing on the
    // frame-end cycle bypasses the shadow and leaves nothing pending.
    always_comb begin
        sombra_d   = sombra_q;
        quadro_d   = quadro_q;
        pendente_d = pendente_q;
        if ((fim || !varrendo) && pendente_q) begin
            quadro_d   = sombra_q;
            pendente_d = 1'b0;
        end
        if (bus.carregar) begin
            sombra_d   = bus.dados_in;
            pendente_d = 1'b1;
        end
        if (fim && bus.carregar) begin
            quadro_d   = bus.dados_in;
            pendente_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sombra_q   <= '0;
            quadro_q   <= '0;
            pendente_q <= 1'b0;
        end else begin
            sombra_q   <= sombra_d;
            quadro_q   <= quadro_d;
            pendente_q <= pendente_d;
        end
    end

    always_comb begin
        bus.colunas = '1;
        if (varrendo) bus.colunas[coluna] = 1'b0;
    end

    assign bus.linhas     = varrendo ? quadro_q[coluna] : '0;
    assign bus.sinal      = !(varrendo && ultimo);
    assign bus.fim_quadro = fim;
endmodule

// File: tb/tb_scan_colunas.sv
// Directed bench for scan_colunas (N_COL=5, DIV=4, 20-cycle frames).
module tb_scan_colunas;
    import scan_colunas_pkg::*;

    localparam int NC = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   falhas = 0;

    scan_colunas_if #(.N_COL(NC)) bus();

    scan_colunas #(.N_COL(NC), .DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic verif(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            falhas++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // tipo 1: column k rows = 01<<k ; tipo 2: column k rows = 40>>k ; else 0
    function automatic logic [6:0] lin_exp(input int tipo, input int k);
        logic [6:0] v;
        v = 7'h00;
        if (tipo == 1) v = 7'h01 << k;
        if (tipo == 2) v = 7'h40 >> k;
        return v;
    endfunction

    function automatic logic [7*NC-1:0] padrao(input int tipo);
        logic [7*NC-1:0] v;
        v = '0;
        for (int k = 0; k < NC; k++) v[7*k +: 7] = lin_exp(tipo, k);
        return v;
    endfunction

    function automatic logic [NC-1:0] col_exp(input int k);
        logic [NC-1:0] v;
        v = '1;
        v[k] = 1'b0;
        return v;
    endfunction

    task automatic verif_idle(input string tag);
        verif({tag, "_colunas"}, bus.colunas, 5'h1F);
        verif({tag, "_linhas"}, bus.linhas, 7'h00);
        verif({tag, "_sinal"}, bus.sinal, 1'b1);
        verif({tag, "_fim"}, bus.fim_quadro, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.carregar = 1'b0;
        bus.dados_in = '0;
        repeat (2) @(negedge clk);
        verif_idle("reset");
        verif("reset_pend", dut.pendente_q, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        verif_idle("idle");
        bus.en = 1'b1;

        // Five frames: zeros, zeros (load mid-frame), P1, P1 (load on fim), P2
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < 20; c++) begin
                int k, tipo;
                @(negedge clk);
                k    = c / 4;
                tipo = (f < 2) ? 0 : (f < 4) ? 1 : 2;
                verif("colunas", bus.colunas, col_exp(k));
                verif("linhas", bus.linhas, lin_exp(tipo, k));
                verif("sinal", bus.sinal, (k == 4) ? 1'b0 : 1'b1);
                verif("fim_quadro", bus.fim_quadro, (c == 19) ? 1'b1 : 1'b0);
                if (f == 1 && c == 6)  verif("pend_meio", dut.pendente_q, 1'b1);
                if (f == 4 && c == 0)  verif("pend_fim", dut.pendente_q, 1'b0);
                bus.carregar = (f == 1 && c == 5) || (f == 3 && c == 19);
                bus.dados_in = (f == 1) ? padrao(1) : padrao(2);
            end
        end

        // Abort at column 2, then restart
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            verif("aborto_col", bus.colunas, col_exp(c / 4));
            verif("aborto_lin", bus.linhas, lin_exp(2, c / 4));
        end
        bus.en = 1'b0;
        @(negedge clk);
        verif_idle("aborto");
        bus.en = 1'b1;
        @(negedge clk);
        verif("reinicio_col", bus.colunas, 5'h1E);
        verif("reinicio_lin", bus.linhas, 7'h40);

        // Reset at column 3 with a load pending, plus a load alongside reset
        repeat (12) @(negedge clk);
        verif("col3", bus.colunas, 5'h17);
        verif("col3_lin", bus.linhas, 7'h08);
        bus.carregar = 1'b1;
        bus.dados_in = padrao(1);
        @(negedge clk);
        verif("pend_antes_rst", dut.pendente_q, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        verif_idle("rst_meio");
        verif("rst_pend", dut.pendente_q, 1'b0);
        verif("rst_quadro", dut.quadro_q, 35'h0);
        rst          = 1'b0;
        bus.carregar = 1'b0;
        @(negedge clk);
        verif("pos_rst_col", bus.colunas, 5'h1E);
        verif("pos_rst_lin", bus.linhas, 7'h00);
        repeat (4) @(negedge clk);
        verif("pos_rst_col1", bus.colunas, 5'h1D);
        verif("pos_rst_lin1", bus.linhas, 7'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, falhas);
        $finish;
    end
endmodule
